// File: rtl/vga_coord_fetch.sv
// Once-per-frame fetch of the sprite coordinate words from data memory, presented
// to bit_gen as (vga_counter, data_from_mem_vga) pairs, one slot per valid cycle.
module vga_coord_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hFFF0,
    parameter int                    NUM_WORDS  = 6,
    parameter int                    READ_LAT   = 1
) (
    input  logic                  clk_25MHz,
    input  logic                  btn_rst_n,
    input  logic                  frame,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] data_from_mem_vga,
    output logic [2:0]            vga_counter,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_issue_idx;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [2:0]            r_slot;
    logic                  r_busy;
    logic                  r_overrun;
    logic [READ_LAT-1:0]   r_pipe_vld;
    logic [2:0]            r_pipe_slot [READ_LAT];

    logic w_accept;
    logic w_last;
    logic w_start;
    logic w_pipe_empty;

    always_comb begin
        w_next_state = r_state;
        w_accept     = r_mem_req && mem_gnt;
        w_last       = w_accept && (r_issue_idx == 3'(NUM_WORDS - 1));
        w_start      = (r_state == S_IDLE) && frame;
        w_pipe_empty = ~|r_pipe_vld;
        case (r_state)
            S_IDLE:  if (frame)        w_next_state = S_ISSUE;
            S_ISSUE: if (w_last)       w_next_state = S_DRAIN;
            S_DRAIN: if (w_pipe_empty) w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            r_state     <= S_IDLE;
            r_issue_idx <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // busy mirrors "not idle next cycle", so a frame during the final DRAIN cycle counts as overrun
            r_busy  <= (w_next_state != S_IDLE);
            if (frame && r_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_start) begin
                r_issue_idx <= '0;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= BASE_ADDR;
            end else if (w_last) begin
                r_issue_idx <= '0;
                r_mem_req   <= 1'b0;
                r_mem_addr  <= '0;
            end else if (w_accept) begin
                r_issue_idx <= r_issue_idx + 3'd1;
                r_mem_addr  <= BASE_ADDR + ADDR_WIDTH'(r_issue_idx + 3'd1);
            end
        end
    end

    // Return pipeline: tag travels READ_LAT cycles so it lines up with mem_rdata
    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_slot[i] <= '0;
            end
            r_data <= '0;
            r_slot <= '0;
        end else begin
            r_pipe_vld[0]  <= w_accept;
            r_pipe_slot[0] <= r_issue_idx + 3'd1;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_slot[i] <= r_pipe_slot[i-1];
            end
            if (r_pipe_vld[READ_LAT-1]) begin
                r_data <= mem_rdata;
                r_slot <= r_pipe_slot[READ_LAT-1];
            end else begin
                r_slot <= '0;
            end
        end
    end

    assign mem_req           = r_mem_req;
    assign mem_addr          = r_mem_addr;
    assign data_from_mem_vga = r_data;
    assign vga_counter       = r_slot;
    assign busy              = r_busy;
    assign overrun           = r_overrun;

endmodule

// File: tb/tb_vga_coord_fetch.sv
// Bench for vga_coord_fetch: two configurations (6 words/lat 1, 7 words/lat 3) driven
// in lockstep and compared every cycle against a slot-schedule reference model.
module tb_vga_coord_fetch;

    localparam logic [15:0] BASE = 16'hFFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic        gnt;
    logic        req0, req1, busy0, busy1, ovr0, ovr1;
    logic [15:0] addr0, addr1, rdata0, rdata1, data0, data1;
    logic [2:0]  vc0, vc1;

    always #20 clk = ~clk;

    vga_coord_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(BASE),
                      .NUM_WORDS(6), .READ_LAT(1)) u_dut0 (
        .clk_25MHz(clk), .btn_rst_n(rst_n), .frame(frame), .mem_gnt(gnt),
        .mem_rdata(rdata0), .mem_req(req0), .mem_addr(addr0),
        .data_from_mem_vga(data0), .vga_counter(vc0), .busy(busy0), .overrun(ovr0));

    vga_coord_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(BASE),
                      .NUM_WORDS(7), .READ_LAT(3)) u_dut1 (
        .clk_25MHz(clk), .btn_rst_n(rst_n), .frame(frame), .mem_gnt(gnt),
        .mem_rdata(rdata1), .mem_req(req1), .mem_addr(addr1),
        .data_from_mem_vga(data1), .vga_counter(vc1), .busy(busy1), .overrun(ovr1));

    // Memory contents and latency-matched read models; junk is returned when no read is due
    logic [15:0] mem [8];
    logic [15:0] junk;
    logic [15:0] a0, a1_0, a1_1, a1_2;
    logic        v0, v1_0, v1_1, v1_2;

    initial begin
        v0 = 1'b0; v1_0 = 1'b0; v1_1 = 1'b0; v1_2 = 1'b0;
        a0 = '0; a1_0 = '0; a1_1 = '0; a1_2 = '0; junk = 16'h5A5A;
    end

    always @(posedge clk) begin
        junk <= 16'($urandom);
        v0   <= req0 && gnt;
        a0   <= addr0 - BASE;
        v1_0 <= req1 && gnt;
        a1_0 <= addr1 - BASE;
        v1_1 <= v1_0; a1_1 <= a1_0;
        v1_2 <= v1_1; a1_2 <= a1_1;
    end

    assign rdata0 = v0   ? mem[a0[2:0]]   : junk;
    assign rdata1 = v1_2 ? mem[a1_2[2:0]] : junk;

    // Reference model: every accepted address k schedules slot k+1 at cycle t+LAT+1
    int          NW [2] = '{6, 7};
    int          LT [2] = '{1, 3};
    bit          m_act  [2];
    int          m_n    [2];
    int          m_last [2];
    bit          m_ovr  [2];
    logic [15:0] m_hold [2];
    int          sched_slot [2][64];
    logic [15:0] sched_data [2][64];
    int          t;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_n[i] = 0; m_last[i] = -1; m_ovr[i] = 1'b0; m_hold[i] = '0;
            for (int j = 0; j < 64; j++) begin
                sched_slot[i][j] = 0;
                sched_data[i][j] = '0;
            end
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            bit          e_req;
            logic [15:0] e_addr;
            int          e_vc;
            e_req  = m_act[i] && (m_n[i] < NW[i]);
            e_addr = e_req ? BASE + 16'(m_n[i]) : 16'h0;
            e_vc   = sched_slot[i][t % 64];
            if (e_vc != 0) m_hold[i] = sched_data[i][t % 64];
            sched_slot[i][t % 64] = 0;
            chk($sformatf("d%0d.req@%0d",  i, t), (i == 0) ? req0  : req1,  32'(e_req));
            chk($sformatf("d%0d.addr@%0d", i, t), (i == 0) ? addr0 : addr1, 32'(e_addr));
            chk($sformatf("d%0d.vc@%0d",   i, t), (i == 0) ? vc0   : vc1,   32'(e_vc));
            chk($sformatf("d%0d.data@%0d", i, t), (i == 0) ? data0 : data1, 32'(m_hold[i]));
            chk($sformatf("d%0d.busy@%0d", i, t), (i == 0) ? busy0 : busy1, 32'(m_act[i]));
            chk($sformatf("d%0d.ovr@%0d",  i, t), (i == 0) ? ovr0  : ovr1,  32'(m_ovr[i]));
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit busy_now;
            busy_now = m_act[i];
            if (busy_now && (m_n[i] < NW[i]) && gnt) begin
                sched_slot[i][(t + LT[i] + 1) % 64] = m_n[i] + 1;
                sched_data[i][(t + LT[i] + 1) % 64] = mem[m_n[i]];
                m_n[i]++;
                if (m_n[i] == NW[i]) m_last[i] = t + LT[i] + 1;
            end
            if (frame && busy_now) m_ovr[i] = 1'b1;
            if (frame && !busy_now) begin
                m_act[i] = 1'b1; m_n[i] = 0; m_last[i] = -1;
            end
            if (busy_now && (m_n[i] == NW[i]) && (t >= m_last[i])) m_act[i] = 1'b0;
        end
    endtask

    task automatic step(input bit f, input bit g);
        check_cycle();
        frame = f;
        gnt   = g;
        model_step();
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},  32'({req0, req1}),   32'h0);
        chk({tag, ".addr"}, {addr0, addr1},      32'h0);
        chk({tag, ".vc"},   32'({vc0, vc1}),     32'h0);
        chk({tag, ".data"}, {data0, data1},      32'h0);
        chk({tag, ".busy"}, 32'({busy0, busy1}), 32'h0);
        chk({tag, ".ovr"},  32'({ovr0, ovr1}),   32'h0);
    endtask

    initial begin
        rst_n = 1'b0; frame = 1'b0; gnt = 1'b0; t = 0;
        model_reset();
        mem[0] = 16'd100; mem[1] = 16'd100; mem[2] = 16'd200; mem[3] = 16'd200;
        mem[4] = 16'd300; mem[5] = 16'd300; mem[6] = 16'd400; mem[7] = 16'd0;
        #10;
        chk_all_zero("reset");
        @(negedge clk);
        step(0, 1); step(0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1);

        // Basic fetch
        for (int i = 0; i < 25; i++) begin
            if (i == 3)  begin chk("basic.vc3", 32'(vc0), 1); chk("basic.d3", 32'(data0), 100); end
            if (i == 8)  begin chk("basic.vc8", 32'(vc0), 6); chk("basic.d8", 32'(data0), 300); end
            if (i == 9)  begin chk("basic.busy9", 32'(busy0), 0); chk("basic.vc9", 32'(vc0), 0); end
            if (i == 5)  begin chk("lat3.vc5", 32'(vc1), 1); chk("lat3.d5", 32'(data1), 100); end
            if (i == 11) begin chk("lat3.vc11", 32'(vc1), 7); chk("lat3.d11", 32'(data1), 400); end
            step(i == 0, 1);
        end

        // Grant stall in cycles 2..4
        for (int i = 0; i < 25; i++) begin
            if (i == 5)  chk("stall.addr5", 32'(addr0), 32'(BASE + 16'd1));
            if (i == 11) chk("stall.vc11", 32'(vc0), 6);
            step(i == 0, !(i >= 2 && i <= 4));
        end

        // Overrun: second frame in cycle 4
        for (int i = 0; i < 25; i++) begin
            if (i == 5) begin chk("ovr.d0", 32'(ovr0), 1); chk("ovr.d1", 32'(ovr1), 1); end
            step(i == 0 || i == 4, 1);
        end

        // Reset asserted asynchronously in the middle of cycle 5
        for (int i = 0; i < 5; i++) step(i == 0, 1);
        #5 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        step(0, 1); step(0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 1);
        for (int i = 0; i < 25; i++) step(i == 0, 1);

        // Back-to-back frames at cycles 0 and 20
        for (int i = 0; i < 45; i++) begin
            if (i == 21) begin
                chk("b2b.req21", 32'(req0), 1);
                chk("b2b.addr21", 32'(addr0), 32'(BASE));
            end
            step(i == 0 || i == 20, 1);
        end
        chk("b2b.ovr", 32'({ovr0, ovr1}), 0);

        // Randomized frames, grant loss and memory contents
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) step(($urandom % 16) == 0, ($urandom % 4) != 0);
        for (int i = 0; i < 20; i++) step(0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_coord_fetch.md
# vga_coord_fetch

Fetches the per-frame sprite coordinate words (monkey x/y, platform 1 x/y, platform 2 x/y) from data memory once per frame. Drives the `data_from_mem_vga` / `vga_counter` pair consumed by the VGA bit generator. It sits between the shared memory read port (via a request/grant arbiter) and `bit_gen`, on the 25 MHz pixel clock. Each word is presented with its slot index for exactly one cycle, so the consumer latches it on that edge.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: memory address width.
- `DATA_WIDTH`, 16: memory word width.
- `BASE_ADDR`, 16'hFFF0: address of coordinate slot 1 (mx).
- `NUM_WORDS`, 6: words fetched per frame. Legal range 1..7, because slot index 0 is reserved for "no write".
- `READ_LAT`, 1: memory read latency in cycles from granted address to `mem_rdata` valid. Legal range 1..4.

Ports:
- `clk_25MHz`, in, 1: pixel clock. This is the only clock.
- `btn_rst_n`, in, 1: reset, asynchronous and active-low.
- `frame`, in, 1: single-cycle start-of-frame pulse from `vga_control`.
- `mem_gnt`, in, 1: arbiter grant. An address is accepted in any cycle with `mem_req && mem_gnt`.
- `mem_rdata`, in, DATA_WIDTH: memory read data.
- `mem_req`, out, 1: request for the memory read port.
- `mem_addr`, out, ADDR_WIDTH: read address. It equals `BASE_ADDR + issue_idx` whenever `mem_req` is high, and 0 otherwise.
- `data_from_mem_vga`, out, DATA_WIDTH: registered coordinate word.
- `vga_counter`, out, 3: slot index (1..NUM_WORDS) for the word currently on `data_from_mem_vga`. It is 0 when no word is valid.
- `busy`, out, 1: a fetch sequence is in progress.
- `overrun`, out, 1: sticky flag. Set when `frame` arrives while `busy` is high.

## Operation
- FSM states:
  - IDLE: default state.
    - On `frame`, go to ISSUE, set `mem_req` = 1, clear `issue_idx`.
  - ISSUE: addresses are being issued.
    - Each accepted cycle increments `issue_idx`.
    - When the accepted address is the one with `issue_idx == NUM_WORDS-1`, drop `mem_req` (registered) and go to DRAIN.
    - If `mem_gnt` is low, hold the address and `issue_idx`; no issue is counted.
  - DRAIN: wait until the return pipeline is empty, then go to IDLE.
- Return pipeline:
  - A READ_LAT-deep shift register carries a valid bit and a slot index of `issue_idx+1` for every accepted address.
  - At the pipeline output, register `mem_rdata` into `data_from_mem_vga` and the slot index into `vga_counter`.
  - In cycles with no return, `vga_counter` is 0 and `data_from_mem_vga` holds its last value.
- Slot indices are always returned in issue order, and each index 1..NUM_WORDS appears exactly once per sequence.
- `busy` is high from the cycle after `frame` until the last `vga_counter` slot has been presented, inclusive.
- Frame while busy:
  - The pulse is ignored; the sequence is not restarted.
  - `overrun` is set and stays set until reset.
- A `frame` pulse in the same cycle that DRAIN completes is also ignored and also sets `overrun`; it is treated as busy.
- Reset (asynchronous, any state, including mid-sequence):
  - State returns to IDLE, the pipeline is cleared, and `issue_idx` = 0.
  - Outputs: `mem_req` = 0, `mem_addr` = 0, `vga_counter` = 0, `data_from_mem_vga` = 0, `busy` = 0, `overrun` = 0.
  - No partial slot is presented after reset is released.

## Timing
- `frame` is sampled high at edge 0.
- Cycle 1: `mem_req` = 1, `mem_addr` = BASE_ADDR, `busy` = 1.
- With `mem_gnt` held high:
  - Addresses BASE_ADDR..BASE_ADDR+NUM_WORDS-1 are issued in cycles 1..NUM_WORDS.
  - `mem_req` = 0 from cycle NUM_WORDS+1.
- Slot k is presented on `vga_counter` in cycle k+READ_LAT+1, so the minimum latency from `frame` to slot 1 is READ_LAT+2 cycles.
- With NUM_WORDS=6 and READ_LAT=1, `vga_counter` steps 1..6 in cycles 3..8, and `busy` falls at cycle 9.
- Each cycle of grant loss delays all later slots by one cycle. The gaps appear as `vga_counter` = 0 cycles.
- Outputs are all registered; no combinational path exists from `mem_rdata` to outputs.

## Test plan
- Basic fetch:
  - Stimulus: memory holds FFF0..FFF5 = 100, 100, 200, 200, 300, 300; `mem_gnt` = 1; pulse `frame`.
  - Required response: `vga_counter`/data = (1,100), (2,100), (3,200), (4,200), (5,300), (6,300) in cycles 3..8, then `vga_counter` = 0 and `busy` = 0 at cycle 9.
- Grant stall:
  - Stimulus: `mem_gnt` low during cycles 2–4.
  - Required response: `mem_addr` holds FFF1 for cycles 2–5, each slot still appears exactly once in order, slot 6 appears in cycle 11, and there are no duplicated or skipped indices.
- Overrun:
  - Stimulus: a second `frame` in cycle 4.
  - Required response: the sequence completes unchanged and `overrun` = 1 from cycle 5 until reset.
- Reset mid-sequence:
  - Stimulus: assert `btn_rst_n` = 0 asynchronously in cycle 5, then release it.
  - Required response: all outputs go to 0 immediately, no `vga_counter` ≠ 0 appears until the next `frame`, and the next `frame` gives a full, correct 6-slot sequence.
- Latency sweep:
  - Stimulus: READ_LAT=3 and NUM_WORDS=7 with a memory model of matching latency.
  - Required response: slots 1..7 appear in cycles 5..11 with the correct data.
- Back-to-back frames:
  - Stimulus: `frame` in cycle 0 and again in cycle 20.
  - Required response: two complete sequences with the second starting in cycle 21, and `overrun` stays 0.
